pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage core (IF, ID, EX, MEM, WB). It combines four inputs into per-stage pipeline-register write enables and bubble-insert controls:
- the ID-stage load-use hazard flag
- the EX-stage taken-branch signal
- the variable-latency data-memory handshake
- the halt request

It also owns the halt/resume state machine and saturating stall/flush performance counters.

---
 rtl/pipeline_ctrl_pkg.sv | 17 +
 rtl/pipeline_ctrl_sat_counter.sv | 30 +++
 rtl/pipeline_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding,
// bubble encoding and wait-counter sizing.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StMemWait = 2'd1,
    StHalt    = 2'd2
  } ctrl_state_e;

  // Bubble loaded by the stage registers on a flush (addi x0, x0, 0).
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam int unsigned   WaitW   = 8;
  localparam logic [WaitW-1:0] WaitMax = 8'hFF;

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with asynchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [Width-1:0] value_o
);

  logic [Width-1:0] value_d, value_q;

  always_comb begin
    value_d = value_q;
    if (inc_i && (value_q != '1)) begin
      value_d = value_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the 5-stage core: per-stage write enables and bubble controls,
// halt/resume and memory-wait FSM, sticky memory timeout and saturating perf counters.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned MAX_WAIT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             halt_req,
  input  logic             resume,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_en,
  output logic             id_ex_flush,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             halted,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WaitW-1:0] MaxWaitW = WaitW'(MAX_WAIT);

  ctrl_state_e      state_d, state_q;
  logic [WaitW-1:0] wait_d, wait_q;
  logic             halted_d, halted_q;
  logic             timeout_d, timeout_q;
  logic             advance;
  logic             halt_entry;
  logic             stall_inc, flush_inc;

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    advance     = 1'b0;
    halt_entry  = 1'b0;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;

    unique case (state_q)
      StRun: begin
        if (halt_req) begin
          state_d    = StHalt;
          halt_entry = 1'b1;
        end else if (mem_req && !mem_ack) begin
          state_d = StMemWait;
          wait_d  = WaitW'(1);
        end else begin
          advance = 1'b1;
        end
      end
      StMemWait: begin
        if (mem_ack) begin
          state_d = StRun;
          advance = 1'b1;
        end else begin
          wait_d = (wait_q == WaitMax) ? wait_q : wait_q + WaitW'(1);
        end
      end
      StHalt: begin
        if (resume) begin
          state_d = StRun;
        end
      end
      default: state_d = StRun;
    endcase

    // A taken branch squashes the ID instruction, so a load hazard is moot that cycle.
    if (advance) begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_hazard) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    if (rst) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      if_id_flush = 1'b0;
      id_ex_en    = 1'b0;
      id_ex_flush = 1'b0;
      ex_mem_en   = 1'b0;
      mem_wb_en   = 1'b0;
    end

    halted_d  = (state_d == StHalt);
    timeout_d = timeout_q || ((state_d == StMemWait) && (wait_d >= MaxWaitW));
  end

  // The cycle that enters HALT belongs to the halt, not to the stall statistics.
  assign stall_inc = !pc_en && (state_q != StHalt) && !halt_entry;
  assign flush_inc = advance && branch_taken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StRun;
      wait_q    <= '0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
    end
  end

  assign halted      = halted_q;
  assign mem_timeout = timeout_q;

  sat_counter #(
    .Width(CNT_W)
  ) u_stall_cnt (
    .clk_i  (clk),
    .clear_i(rst),
    .inc_i  (stall_inc),
    .value_o(stall_cnt)
  );

  sat_counter #(
    .Width(CNT_W)
  ) u_flush_cnt (
    .clk_i  (clk),
    .clear_i(rst),
    .inc_i  (flush_inc),
    .value_o(flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios then randomized traffic,
// all compared against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_ctrl;

  localparam int unsigned CntW    = 5;
  localparam int unsigned MaxWait = 4;
  localparam int          CntMax  = (1 << CntW) - 1;

  logic            clk = 1'b0;
  logic            rst;
  logic            load_hazard, branch_taken, mem_req, mem_ack, halt_req, resume;
  logic            pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic            halted, mem_timeout;
  logic [CntW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .CNT_W   (CntW),
    .MAX_WAIT(MaxWait)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_hazard (load_hazard),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ack     (mem_ack),
    .halt_req    (halt_req),
    .resume      (resume),
    .pc_en       (pc_en),
    .if_id_en    (if_id_en),
    .if_id_flush (if_id_flush),
    .id_ex_en    (id_ex_en),
    .id_ex_flush (id_ex_flush),
    .ex_mem_en   (ex_mem_en),
    .mem_wb_en   (mem_wb_en),
    .halted      (halted),
    .mem_timeout (mem_timeout),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model: 0 = running, 1 = waiting on memory, 2 = halted.
  int m_mode, m_wait, m_stall, m_flush;
  bit m_timeout;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_wait    = 0;
    m_stall   = 0;
    m_flush   = 0;
    m_timeout = 0;
  endtask

  function automatic logic [6:0] en_vec();
    return {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};
  endfunction

  task automatic check_regs();
    check("halted", 32'(halted), 32'(m_mode == 2));
    check("mem_timeout", 32'(mem_timeout), 32'(m_timeout));
    check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
    check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit lh, input bit bt, input bit mr, input bit ma, input bit hr,
                      input bit rs);
    bit         flows;
    logic [6:0] exp_en;
    @(negedge clk);
    load_hazard  = lh;
    branch_taken = bt;
    mem_req      = mr;
    mem_ack      = ma;
    halt_req     = hr;
    resume       = rs;
    #1;
    flows = (m_mode == 0 && !hr && !(mr && !ma)) || (m_mode == 1 && ma);
    if (!flows)  exp_en = 7'b000_0000;
    else if (bt) exp_en = 7'b111_1111;
    else if (lh) exp_en = 7'b000_1111;
    else         exp_en = 7'b110_1011;
    check("enables", 32'(en_vec()), 32'(exp_en));
    check_regs();

    if (m_mode != 2 && !(m_mode == 0 && hr) && !exp_en[6]) begin
      m_stall = (m_stall < CntMax) ? m_stall + 1 : m_stall;
    end
    if (flows && bt) m_flush = (m_flush < CntMax) ? m_flush + 1 : m_flush;
    case (m_mode)
      0: begin
        if (hr) m_mode = 2;
        else if (mr && !ma) begin
          m_mode = 1;
          m_wait = 1;
        end
      end
      1: begin
        if (ma) begin
          m_mode = 0;
          m_wait = 0;
        end else begin
          m_wait = (m_wait < 255) ? m_wait + 1 : 255;
        end
      end
      default: if (rs) m_mode = 0;
    endcase
    if (m_mode == 1 && m_wait >= MaxWait) m_timeout = 1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst          = 1'b1;
    load_hazard  = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ack      = 1'b0;
    halt_req     = 1'b0;
    resume       = 1'b0;
    model_reset();
    #1;
    check("rst_enables", 32'(en_vec()), 32'd0);
    check_regs();
    #21 rst = 1'b0;

    // Load hazard: one bubble, then normal flow.
    step(1, 0, 0, 0, 0, 0);
    idle();
    check("lh_stall_cnt", 32'(stall_cnt), 32'd1);

    // Branch beats load hazard.
    step(1, 1, 0, 0, 0, 0);
    idle();
    check("br_flush_cnt", 32'(flush_cnt), 32'd1);
    check("br_stall_cnt", 32'(stall_cnt), 32'd1);

    // Memory wait: three stalled cycles, then ack.
    repeat (3) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    idle();
    check("mw_stall_cnt", 32'(stall_cnt), 32'd4);
    check("mw_timeout", 32'(mem_timeout), 32'd0);

    // Halt, sit halted, then resume.
    step(0, 0, 0, 0, 1, 0);
    repeat (5) idle();
    step(0, 0, 0, 0, 0, 1);
    idle();
    check("halt_stall_cnt", 32'(stall_cnt), 32'd4);

    // Timeout: six cycles without ack; flag is sticky past the ack.
    repeat (6) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 1, 0, 0);
    idle();
    check("to_sticky", 32'(mem_timeout), 32'd1);

    // Asynchronous reset in the middle of a memory wait.
    repeat (2) step(0, 0, 1, 0, 0, 0);
    @(posedge clk);
    #3;
    rst     = 1'b1;
    mem_req = 1'b0;
    #1;
    model_reset();
    check("arst_enables", 32'(en_vec()), 32'd0);
    check_regs();
    @(negedge clk);
    #2 rst = 1'b0;
    idle();
    idle();

    // Randomized traffic, saturating both counters along the way.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 20,
           $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 45,
           $urandom_range(0, 99) < 5,  $urandom_range(0, 99) < 30);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
